layer_link: RTL and testbench
=============================

Name: layer_link

Overview:
- Inter-layer handoff stage between two fc_layer instances.
- Consumes the activation stream from an upstream fc_layer function unit (o_func_data plus a valid strobe).
- Writes each activation into the downstream fc_layer input buffer (i_ibuf_we / i_ibuf_wr_data / i_ibuf_addr), then issues i_start once a full vector is loaded.
- Back-pressures upstream via its i_next_busy while the downstream layer is computing.

Parameters:
- datatype_size, 8, activation width in bits.
- input_size, 784, downstream layer input count; equals upstream output_size.
- cnt_width, 16, width of the frame counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- i_func_valid  input  1  upstream activation valid.
- i_func_data  input  datatype_size  upstream activation (o_func_data of layer N).
- o_next_busy  output  1  to upstream i_next_busy; high means no beat is accepted.
- o_ibuf_we  output  1  downstream i_ibuf_we.
- o_ibuf_wr_data  output  datatype_size  downstream i_ibuf_wr_data.
- o_ibuf_addr  output  $clog2(input_size)  downstream i_ibuf_addr.
- o_start  output  1  downstream i_start, one-cycle pulse.
- i_busy  input  1  downstream o_busy.
- o_frame_cnt  output  cnt_width  completed handoffs, wraps modulo 2^cnt_width.
- o_overrun  output  1  sticky: a valid beat arrived while o_next_busy was high.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_start, o_frame_cnt and o_overrun are all 0.
  - The state is FILL and the beat counter is 0.
- States: FILL, LOAD, START, ACK, DRAIN.
- o_next_busy is combinational: (state != FILL) | i_busy.
- Accept condition: i_func_valid & !o_next_busy in the same cycle.
- Accepted beat at cycle t:
  - At t+1, o_ibuf_we=1, o_ibuf_addr = beat counter value, o_ibuf_wr_data = the data.
  - The counter increments.
  - o_ibuf_we is 0 in every other cycle.
- FILL -> LOAD when the beat with counter == input_size-1 is accepted.
  - The counter returns to 0; no power-of-two wrap (784 uses addresses 0..783 only).
- LOAD, one cycle: the final write is on the ibuf port. -> START.
- START: o_start=1 for exactly one cycle, i.e. t+2 after the last accepted beat. -> ACK.
- ACK: wait for i_busy=1, then -> DRAIN. No timeout.
- DRAIN: wait for i_busy=0.
  - o_frame_cnt increments in the same cycle as the -> FILL transition.
  - o_next_busy falls in the following cycle, unless i_busy is high.
- If i_busy is high during FILL, acceptance stalls and the counter holds; no state change.
- Beats with i_func_valid=1 while o_next_busy=1 are dropped and set o_overrun. It stays set until reset.
- Simultaneous accept and i_busy rise: o_next_busy is combinational, so i_busy=1 blocks acceptance in that cycle.
- Reset mid-fill discards the partial vector. Reset during ACK/DRAIN drops the pending handshake; the downstream layer is not re-started.
- Data passes unmodified, except under the optional feature.

Optional Feature:
- Macro: LAYER_LINK_RELU_EN.
- Defined: each accepted beat is treated as signed. If the MSB is 1, o_ibuf_wr_data = 0; otherwise it passes. Latency is unchanged.
- Undefined: no data modification; all values pass through.

Decomposition:
- layer_link_pkg holds:
  - the state enum typedef (FILL, LOAD, START, ACK, DRAIN);
  - a constant function for addr width ($clog2 wrapper clamped to minimum 1).
- No sub-module; counter, FSM and optional ReLU live in one module.

Test Plan:
- input_size=4, send 4 beats 0x11,0x22,0x33,0x44 back-to-back with i_busy=0:
  - o_ibuf_we on 4 consecutive cycles at addr 0..3 with matching data;
  - o_start single pulse 2 cycles after the 4th accepted beat;
  - o_next_busy high from the cycle after the 4th beat.
- After start, hold i_busy=1 for 10 cycles then 0:
  - o_next_busy stays high throughout;
  - o_frame_cnt goes 0 -> 1 as i_busy falls;
  - a second 4-beat frame writes addr 0..3 again.
- Assert i_busy=1 after beat 2 during FILL:
  - beats 3-4 held off (o_next_busy=1), no writes;
  - on release the writes resume at addr 2.
- Drive i_func_valid=1 with data 0x55 during ACK: no write, o_overrun=1 and stays 1 through the next full frame.
- Pulse rst=0 asynchronously after beat 2: all outputs 0 immediately; a subsequent 4-beat frame starts at addr 0 and produces exactly one o_start.
- With LAYER_LINK_RELU_EN, send 0x80,0x7F,0xFF,0x01 -> written data 0x00,0x7F,0x00,0x01. Without the macro, the values are unchanged.

Source files
------------

// File: rtl/layer_link_pkg.sv
// Shared types and helpers for the inter-layer handoff stage (layer_link).
package layer_link_pkg;

   typedef enum logic [2:0] {
      FILL  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   // $clog2 clamped so a one- or two-entry buffer still gets a 1-bit address.
   function automatic int addr_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/layer_link.sv
// Hands an activation stream from one fc_layer into the next layer's input
// buffer, then starts it. Optional build macro LAYER_LINK_RELU_EN clamps negative beats to 0.
module layer_link
   import layer_link_pkg::*;
#(
   parameter int datatype_size = 8,
   parameter int input_size    = 784,
   parameter int cnt_width     = 16,
   localparam int AW           = addr_w(input_size)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_func_valid,
   input  logic [datatype_size-1:0] i_func_data,
   output logic                     o_next_busy,
   output logic                     o_ibuf_we,
   output logic [datatype_size-1:0] o_ibuf_wr_data,
   output logic [AW-1:0]            o_ibuf_addr,
   output logic                     o_start,
   input  logic                     i_busy,
   output logic [cnt_width-1:0]     o_frame_cnt,
   output logic                     o_overrun
);

   localparam logic [AW-1:0] LAST = AW'(input_size - 1);

   state_t                     r_state;
   logic [AW-1:0]              r_cnt;
   logic                       r_we;
   logic [datatype_size-1:0]   r_data;
   logic [AW-1:0]              r_addr;
   logic                       r_start;
   logic [cnt_width-1:0]       r_frame;
   logic                       r_overrun;

   logic                       w_next_busy;
   logic                       w_accept;
   logic [datatype_size-1:0]   w_data;

   // Combinational so a downstream busy rise blocks the very beat it coincides with.
   assign w_next_busy = (r_state != FILL) | i_busy;
   assign w_accept    = i_func_valid & ~w_next_busy;

`ifdef LAYER_LINK_RELU_EN
   assign w_data = i_func_data[datatype_size-1] ? '0 : i_func_data;
`else
   assign w_data = i_func_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= FILL;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_data    <= '0;
         r_addr    <= '0;
         r_start   <= 1'b0;
         r_frame   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_we    <= 1'b0;
         r_start <= 1'b0;
         if (i_func_valid & w_next_busy)
            r_overrun <= 1'b1;
         unique case (r_state)
            FILL: begin
               if (w_accept) begin
                  r_we   <= 1'b1;
                  r_addr <= r_cnt;
                  r_data <= w_data;
                  if (r_cnt == LAST) begin
                     r_cnt   <= '0;
                     r_state <= LOAD;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            // Final write is on the ibuf port this cycle; start follows it.
            LOAD: begin
               r_start <= 1'b1;
               r_state <= START;
            end
            START: r_state <= ACK;
            ACK: begin
               if (i_busy)
                  r_state <= DRAIN;
            end
            DRAIN: begin
               if (!i_busy) begin
                  r_frame <= r_frame + 1'b1;
                  r_state <= FILL;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign o_next_busy    = w_next_busy;
   assign o_ibuf_we      = r_we;
   assign o_ibuf_wr_data = r_data;
   assign o_ibuf_addr    = r_addr;
   assign o_start        = r_start;
   assign o_frame_cnt    = r_frame;
   assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_layer_link.sv
// Self-checking bench for layer_link: directed scenarios plus random traffic
// compared against a timing-level reference model of the handoff protocol.
module tb_layer_link;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int CW = 16;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_func_valid = 1'b0;
   logic [DW-1:0] i_func_data = '0;
   logic          i_busy = 1'b0;
   logic          o_next_busy, o_ibuf_we, o_start, o_overrun;
   logic [DW-1:0] o_ibuf_wr_data;
   logic [AW-1:0] o_ibuf_addr;
   logic [CW-1:0] o_frame_cnt;

   always #5 clk = ~clk;

   layer_link #(.datatype_size(DW), .input_size(N), .cnt_width(CW)) dut (
      .clk(clk), .rst(rst),
      .i_func_valid(i_func_valid), .i_func_data(i_func_data),
      .o_next_busy(o_next_busy),
      .o_ibuf_we(o_ibuf_we), .o_ibuf_wr_data(o_ibuf_wr_data), .o_ibuf_addr(o_ibuf_addr),
      .o_start(o_start), .i_busy(i_busy),
      .o_frame_cnt(o_frame_cnt), .o_overrun(o_overrun)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: beats gathered so far, whether a handoff is outstanding,
   // edges elapsed since the last beat, and whether the downstream has gone busy.
   int            m_beats, m_since, m_frame, n_starts;
   bit            m_pend, m_seen, m_ovr, e_we, e_start;
   int            e_addr;
   logic [DW-1:0] e_data;

   function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] d);
`ifdef LAYER_LINK_RELU_EN
      return (d >= 8'h80) ? 8'h00 : d;
`else
      return d;
`endif
   endfunction

   task automatic model_reset();
      m_beats = 0; m_since = 0; m_frame = 0; m_pend = 0; m_seen = 0; m_ovr = 0;
      e_we = 0; e_start = 0; e_addr = 0; e_data = '0;
   endtask

   // One clock: drive inputs just after an edge, check next_busy, predict, then check registered outputs.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit b);
      bit nb, acc;
      i_func_valid = v; i_func_data = d; i_busy = b;
      #1;
      nb = m_pend | b;
      chk("next_busy", {31'd0, o_next_busy}, {31'd0, nb});
      acc = v & ~nb;
      if (v & nb) m_ovr = 1;
      e_we = 0; e_start = 0;
      if (acc) begin
         e_we = 1; e_addr = m_beats; e_data = ref_data(d);
         m_beats++;
         if (m_beats == N) begin
            m_beats = 0; m_pend = 1; m_since = 0; m_seen = 0;
         end
      end else if (m_pend) begin
         if (m_since == 0) begin
            m_since = 1; e_start = 1;
         end else if (m_since == 1) begin
            m_since = 2;
         end else if (!m_seen) begin
            if (b) m_seen = 1;
         end else if (!b) begin
            m_pend = 0; m_frame++;
         end
      end
      @(posedge clk); #1;
      chk("ibuf_we", {31'd0, o_ibuf_we}, {31'd0, e_we});
      if (e_we) begin
         chk("ibuf_addr", {30'd0, o_ibuf_addr}, e_addr);
         chk("ibuf_data", {24'd0, o_ibuf_wr_data}, {24'd0, e_data});
      end
      chk("start", {31'd0, o_start}, {31'd0, e_start});
      if (o_start) n_starts++;
      chk("frame_cnt", {16'd0, o_frame_cnt}, m_frame & 32'hFFFF);
      chk("overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
   endtask

   task automatic send_frame(input logic [DW-1:0] d0, d1, d2, d3);
      step(1, d0, 0); step(1, d1, 0); step(1, d2, 0); step(1, d3, 0);
   endtask

   task automatic finish_handshake(input int busy_cycles);
      step(0, 0, 0); step(0, 0, 0);
      for (int i = 0; i < busy_cycles; i++) step(0, 0, 1);
      step(0, 0, 0); step(0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_we"},      {31'd0, o_ibuf_we},      0);
      chk({pfx, "_addr"},    {30'd0, o_ibuf_addr},    0);
      chk({pfx, "_data"},    {24'd0, o_ibuf_wr_data}, 0);
      chk({pfx, "_start"},   {31'd0, o_start},        0);
      chk({pfx, "_frame"},   {16'd0, o_frame_cnt},    0);
      chk({pfx, "_overrun"}, {31'd0, o_overrun},      0);
      chk({pfx, "_nbusy"},   {31'd0, o_next_busy},    0);
   endtask

   initial begin
      int s0;
      model_reset();
      n_starts = 0;
      #2 rst = 1'b0;
      #1 check_reset_outputs("rst0");
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Back-to-back frame, then downstream busy for 10 cycles.
      s0 = n_starts;
      send_frame(8'h11, 8'h22, 8'h33, 8'h44);
      finish_handshake(10);
      chk("frame1_starts", n_starts - s0, 1);
      chk("frame1_cnt", {16'd0, o_frame_cnt}, 1);

      // Second frame reuses addresses 0..3; stall after beat 2.
      step(1, 8'h01, 0); step(1, 8'h02, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h03, 1);
      step(1, 8'h03, 0); step(1, 8'h04, 0);
      finish_handshake(3);
      chk("frame2_cnt", {16'd0, o_frame_cnt}, 2);

      // Valid beat during ACK is dropped and latches overrun.
      send_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      step(0, 0, 0); step(0, 0, 0);
      step(1, 8'h55, 0);
      chk("overrun_set", {31'd0, o_overrun}, 1);
      step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
      send_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
      finish_handshake(2);
      chk("overrun_sticky", {31'd0, o_overrun}, 1);

      // Asynchronous reset mid-fill discards the partial vector.
      step(1, 8'hC0, 0); step(1, 8'hC1, 0);
      i_func_valid = 0; i_busy = 0;
      #2 rst = 1'b0;
      #1 check_reset_outputs("rst_mid");
      @(negedge clk); rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      s0 = n_starts;
      send_frame(8'hD0, 8'hD1, 8'hD2, 8'hD3);
      finish_handshake(2);
      chk("post_rst_starts", n_starts - s0, 1);

      // Sign-boundary values: clamped only with the ReLU build.
      send_frame(8'h80, 8'h7F, 8'hFF, 8'h01);
      finish_handshake(1);

      // Random traffic with random downstream busy.
      for (int i = 0; i < 600; i++)
         step(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) == 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
